// File: rtl/risc_datapath.sv
// Accumulator datapath: PC, IR, AC, ALU and memory strobes under controller command.
// Optional RISC_DP_CARRY_EN adds a registered ADD carry-out port.
module risc_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            current_state,
    input  logic                  mem_rd,
    input  logic                  load_ir,
    input  logic                  inc_pc,
    input  logic                  load_pc,
    input  logic                  load_ac,
    input  logic                  mem_rw,
    input  logic                  halt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [2:0]            opcode,
    output logic                  zero,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
`ifdef RISC_DP_CARRY_EN
    output logic                  carry,
`endif
    output logic                  proto_err
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [ADDR_WIDTH-1:0] ir_addr;

    assign ir_addr = ir_q[ADDR_WIDTH-1:0];
    assign opcode  = ir_q[DATA_WIDTH-1 -: 3];

`ifdef RISC_DP_CARRY_EN
    logic              carry_q, carry_d;
    logic [DATA_WIDTH:0] sum;

    assign sum   = {1'b0, ac_q} + {1'b0, mem_rdata};
    assign carry = carry_q;
`endif

    always_comb begin
        alu_res = ac_q;
        unique case (opcode)
`ifdef RISC_DP_CARRY_EN
            OP_ADD:  alu_res = sum[DATA_WIDTH-1:0];
`else
            OP_ADD:  alu_res = ac_q + mem_rdata;
`endif
            OP_AND:  alu_res = ac_q & mem_rdata;
            OP_XOR:  alu_res = ac_q ^ mem_rdata;
            OP_LDA:  alu_res = mem_rdata;
            default: alu_res = ac_q;
        endcase
    end

    // Halt freezes the architectural registers; load_pc outranks inc_pc.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        ac_d = ac_q;
        if (!halt) begin
            if (load_pc) begin
                pc_d = ir_addr;
            end else if (inc_pc) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
            if (load_ir) begin
                ir_d = mem_rdata;
            end
            if (load_ac) begin
                ac_d = alu_res;
            end
        end
    end

`ifdef RISC_DP_CARRY_EN
    always_comb begin
        carry_d = carry_q;
        if (!halt && load_ac) begin
            unique case (opcode)
                OP_ADD:                 carry_d = sum[DATA_WIDTH];
                OP_AND, OP_XOR, OP_LDA: carry_d = 1'b0;
                default:                carry_d = carry_q;
            endcase
        end
    end
`endif

    assign perr_d = perr_q | (mem_rd & mem_rw);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= '0;
            ir_q   <= '0;
            ac_q   <= '0;
            perr_q <= 1'b0;
`ifdef RISC_DP_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            ac_q   <= ac_d;
            perr_q <= perr_d;
`ifdef RISC_DP_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign mem_addr  = current_state[2] ? ir_addr : pc_q;
    assign mem_wdata = ac_q;
    assign mem_re    = mem_rd;
    assign mem_we    = mem_rw & ~mem_rd & ~halt & ~reset;
    assign zero      = (ac_q == '0);
    assign pc        = pc_q;
    assign ac        = ac_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Scoreboard bench for risc_datapath: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_risc_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] current_state;
    logic       mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_rw, halt;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_re, mem_we;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] pc;
    logic [7:0] ac;
    logic       proto_err;
`ifdef RISC_DP_CARRY_EN
    logic       carry;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    risc_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk(clk),
        .reset(reset),
        .current_state(current_state),
        .mem_rd(mem_rd),
        .load_ir(load_ir),
        .inc_pc(inc_pc),
        .load_pc(load_pc),
        .load_ac(load_ac),
        .mem_rw(mem_rw),
        .halt(halt),
        .mem_rdata(mem_rdata),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_re(mem_re),
        .mem_we(mem_we),
        .opcode(opcode),
        .zero(zero),
        .pc(pc),
        .ac(ac),
`ifdef RISC_DP_CARRY_EN
        .carry(carry),
`endif
        .proto_err(proto_err)
    );

    // -1 in a field means "not checked this cycle"
    typedef struct {
        string nm;
        int pc, ac, op, zero, addr, we, re, wdata, perr, carry;
    } exp_t;

    exp_t q[$];

    function automatic exp_t blank(string nm);
        exp_t e;
        e.nm = nm;
        e.pc = -1; e.ac = -1; e.op = -1; e.zero = -1; e.addr = -1;
        e.we = -1; e.re = -1; e.wdata = -1; e.perr = -1; e.carry = -1;
        return e;
    endfunction

    task automatic chk(string nm, string fld, int act, int expv);
        if (expv >= 0) begin
            checks++;
            if (act != expv) begin
                errors++;
                $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, expv);
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "pc", int'(pc), e.pc);
            chk(e.nm, "ac", int'(ac), e.ac);
            chk(e.nm, "opcode", int'(opcode), e.op);
            chk(e.nm, "zero", int'(zero), e.zero);
            chk(e.nm, "mem_addr", int'(mem_addr), e.addr);
            chk(e.nm, "mem_we", int'(mem_we), e.we);
            chk(e.nm, "mem_re", int'(mem_re), e.re);
            chk(e.nm, "mem_wdata", int'(mem_wdata), e.wdata);
            chk(e.nm, "proto_err", int'(proto_err), e.perr);
`ifdef RISC_DP_CARRY_EN
            chk(e.nm, "carry", int'(carry), e.carry);
`endif
        end
    end

    task automatic drive(input int st, input bit rd, input bit ir, input bit inc,
                         input bit lpc, input bit lac, input bit rw,
                         input bit hlt, input bit rst, input logic [7:0] rdata);
        @(posedge clk);
        #1;
        current_state = st[2:0];
        mem_rd    = rd;
        load_ir   = ir;
        inc_pc    = inc;
        load_pc   = lpc;
        load_ac   = lac;
        mem_rw    = rw;
        halt      = hlt;
        reset     = rst;
        mem_rdata = rdata;
    endtask

    task automatic idle(input int st);
        drive(st, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1; current_state = '0; mem_rd = 0; load_ir = 0; inc_pc = 0;
        load_pc = 0; load_ac = 0; mem_rw = 0; halt = 0; mem_rdata = '0;

        drive($urandom_range(7), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1,
              8'($urandom));
        drive($urandom_range(7), 0, 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1, 1'($urandom), 1, 8'($urandom));
        e = blank("reset");
        e.pc = 0; e.ac = 0; e.op = 0; e.zero = 1; e.perr = 0; e.we = 0; e.carry = 0;
        q.push_back(e);

        idle(0);
        e = blank("rst_idle"); e.pc = 0; e.addr = 0; e.re = 0; e.we = 0;
        q.push_back(e);

        drive(2, 1, 1, 0, 0, 0, 0, 0, 0, 8'hA3);
        e = blank("fetch_comb"); e.addr = 0; e.re = 1; e.we = 0; e.op = 0;
        q.push_back(e);

        idle(4);
        e = blank("fetch_ir"); e.op = 5; e.addr = 5'h03;
        q.push_back(e);

        drive(5, 1, 0, 0, 0, 1, 0, 0, 0, 8'h0F);
        e = blank("lda_pre"); e.ac = 0; e.zero = 1;
        q.push_back(e);

        idle(0);
        e = blank("lda"); e.ac = 8'h0F; e.zero = 0; e.carry = 0;
        q.push_back(e);

        drive(2, 0, 1, 0, 0, 0, 0, 0, 0, 8'h52);
        idle(4);
        e = blank("ir_nogate"); e.op = 2; e.addr = 5'h12;
        q.push_back(e);

        drive(5, 1, 0, 0, 0, 1, 0, 0, 0, 8'hF1);
        e = blank("add_comb"); e.ac = 8'h0F; e.re = 1;
        q.push_back(e);

        idle(0);
        e = blank("add_wrap"); e.ac = 0; e.zero = 1; e.carry = 1;
        q.push_back(e);

        drive(6, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00);
        idle(0);
        e = blank("pc_prio"); e.pc = 5'h12;
        q.push_back(e);

        drive(2, 1, 1, 0, 0, 0, 0, 0, 0, 8'h7F);
        drive(5, 1, 0, 0, 1, 1, 0, 0, 0, 8'hC3);
        e = blank("and_ir"); e.op = 3;
        q.push_back(e);

        idle(0);
        e = blank("pc_load"); e.pc = 5'h1F; e.ac = 0; e.carry = 0;
        q.push_back(e);

        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        idle(0);
        e = blank("pc_wrap"); e.pc = 0;
        q.push_back(e);

        drive(2, 1, 1, 0, 0, 0, 0, 0, 0, 8'h87);
        drive(5, 1, 0, 1, 0, 1, 0, 0, 0, 8'h55);
        e = blank("xor_ir"); e.op = 4; e.addr = 5'h07;
        q.push_back(e);

        drive(7, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        e = blank("store");
        e.ac = 8'h55; e.zero = 0; e.pc = 1; e.we = 1; e.re = 0;
        e.wdata = 8'h55; e.addr = 5'h07; e.perr = 0;
        q.push_back(e);

        drive(7, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        e = blank("collide"); e.we = 0; e.re = 1; e.perr = 0;
        q.push_back(e);

        idle(0);
        e = blank("perr_set"); e.perr = 1;
        q.push_back(e);

        idle(0);
        e = blank("perr_hold"); e.perr = 1;
        q.push_back(e);

        drive(7, 0, 1, 1, 1, 1, 1, 1, 0, 8'hFF);
        e = blank("halt_we"); e.we = 0; e.pc = 1; e.ac = 8'h55;
        q.push_back(e);

        drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
        e = blank("halt_hold");
        e.pc = 1; e.ac = 8'h55; e.op = 4; e.re = 1; e.we = 0; e.perr = 1;
        q.push_back(e);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h00);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
        e = blank("halt_rst");
        e.pc = 0; e.ac = 0; e.op = 0; e.zero = 1; e.perr = 0; e.carry = 0;
        q.push_back(e);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
